// File: rtl/mult_pkg.sv
// Shared definitions for the iterative EX-stage multiplier: FSM encoding and
// chunking constants.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_CHUNKS = 4;
    localparam int CNT_W      = 2;

endpackage

// File: rtl/mult_pp_gen.sv
// Combinational partial-product generator: A times one B chunk, shifted into
// place and truncated to DATA_W bits.
module mult_pp_gen
    import mult_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]            a,
    input  logic [DATA_W/NUM_CHUNKS-1:0] b_chunk,
    input  logic [CNT_W-1:0]             idx,
    output logic [DATA_W-1:0]            pp
);

    localparam int CHUNK = DATA_W / NUM_CHUNKS;

    logic [DATA_W-1:0] prod;

    // Only the low DATA_W bits survive, so a truncating multiply is enough.
    assign prod = a * DATA_W'(b_chunk);
    assign pp   = prod << (32'(idx) * CHUNK);

endmodule

// File: rtl/mult_iter_unit.sv
// Four-cycle iterative multiplier for EX: one B chunk per cycle, stalls the
// front end while busy and presents the low product bits for one cycle.
module mult_iter_unit
    import mult_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic [REG_W-1:0]  rd_o
);

    localparam int CHUNK = DATA_W / NUM_CHUNKS;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [REG_W-1:0]  rd_q;
    logic              valid_q;

    logic [DATA_W-1:0] pp_a;
    logic [CHUNK-1:0]  pp_b;
    logic [CNT_W-1:0]  pp_idx;
    logic [DATA_W-1:0] pp;

    // In IDLE chunk 0 comes straight from the forwarded operands so the
    // accepting edge already loads the first partial product.
    always_comb begin
        pp_a   = a_q;
        pp_b   = b_q[cnt*CHUNK +: CHUNK];
        pp_idx = cnt;
        if (state == IDLE) begin
            pp_a   = op_a_i;
            pp_b   = op_b_i[CHUNK-1:0];
            pp_idx = '0;
        end
    end

    mult_pp_gen #(
        .DATA_W (DATA_W)
    ) u_pp_gen (
        .a       (pp_a),
        .b_chunk (pp_b),
        .idx     (pp_idx),
        .pp      (pp)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q   <= op_a_i;
                        b_q   <= op_b_i;
                        rd_q  <= rd_i;
                        acc   <= pp;
                        cnt   <= CNT_W'(1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc + pp;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_CHUNKS - 1)) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Combinational on start_i so the hazard unit freezes in the issue cycle.
    assign stall_o  = ((state == IDLE) && start_i && !flush_i) || (state == BUSY);
    assign valid_o  = valid_q;
    assign result_o = acc;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_mult_iter_unit.sv
// Randomized scoreboard bench for mult_iter_unit: a cycle-level reference of
// issue/flush timing plus plain 64-bit multiplication for the result.
module tb_mult_iter_unit;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    logic              clk;
    logic              arst_n;
    logic              start_i;
    logic              flush_i;
    logic [DATA_W-1:0] op_a_i;
    logic [DATA_W-1:0] op_b_i;
    logic [REG_W-1:0]  rd_i;
    logic              stall_o;
    logic              valid_o;
    logic [DATA_W-1:0] result_o;
    logic [REG_W-1:0]  rd_o;

    mult_iter_unit #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .rd_i     (rd_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] res;
        logic [REG_W-1:0]  rd;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    bit   exp_stall_now = 1'b0;

    // Reference model state: is an operation in flight, and its issue cycle.
    bit   inflight = 1'b0;
    int   t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_cycle(input bit st, input bit fl, input logic [63:0] a,
                               input logic [63:0] b, input logic [REG_W-1:0] r);
        int c;
        bit idle_now;
        logic [63:0] prod;
        @(posedge clk);
        #1;
        c       = cyc;
        start_i = st;
        flush_i = fl;
        op_a_i  = a;
        op_b_i  = b;
        rd_i    = r;
        if (inflight && c >= t0 + 5) inflight = 1'b0;
        idle_now = !inflight;
        exp_stall_now = (inflight && c >= t0 + 1 && c <= t0 + 3) || (idle_now && st && !fl);
        if (fl) begin
            if (inflight && c < t0 + 4) sb.delete(sb.size() - 1);
            inflight = 1'b0;
        end else if (idle_now && st) begin
            inflight = 1'b1;
            t0 = c;
            prod = a * b;
            sb.push_back('{res: prod, rd: r, cyc: c + 4});
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, rnd64(), rnd64(), REG_W'($urandom));
    endtask

    task automatic do_reset_mid();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        exp_stall_now = 1'b0;
        #1 arst_n = 1'b0;
        #1;
        chk("rst_mid_result", result_o, 64'd0);
        chk("rst_mid_rd", 64'(rd_o), 64'd0);
        chk("rst_mid_valid", 64'(valid_o), 64'd0);
        chk("rst_mid_stall", 64'(stall_o), 64'd0);
        inflight = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    // Monitor: per-cycle stall check and scoreboard pop on every valid_o.
    always @(negedge clk) begin
        if (arst_n) begin
            chk("stall", 64'(stall_o), 64'(exp_stall_now));
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                $display("FAIL missing_valid at cycle %0d: got no valid expected valid at cycle %0d",
                         cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (valid_o) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_valid at cycle %0d: got valid_o=1 expected 0 (result %h)",
                             cyc, result_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_cycle", 64'(cyc), 64'(e.cyc));
                    chk("result", result_o, e.res);
                    chk("rd", 64'(rd_o), 64'(e.rd));
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                total++;
                $display("FAIL missing_valid at cycle %0d: got valid_o=0 expected 1", cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        arst_n  = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_a_i  = '0;
        op_b_i  = '0;
        rd_i    = '0;
        #3;
        chk("rst_result", result_o, 64'd0);
        chk("rst_rd", 64'(rd_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (2) idle_cycle();

        // Directed corner cases.
        drive_cycle(1'b1, 1'b0, 64'd7, 64'd6, 5'd5);
        repeat (6) idle_cycle();
        drive_cycle(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd9);
        repeat (6) idle_cycle();
        drive_cycle(1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd10);
        repeat (6) idle_cycle();
        drive_cycle(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0001_0001_0001_0001, 5'd31);
        repeat (6) idle_cycle();

        // Random operands with random gaps.
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 1'b0, rnd64(), rnd64(), REG_W'($urandom));
            repeat ($urandom_range(3, 7)) idle_cycle();
        end

        // start_i held high: accepts only every fifth cycle.
        repeat (12) drive_cycle(1'b1, 1'b0, rnd64(), rnd64(), REG_W'($urandom));
        repeat (6) idle_cycle();

        // Flush two cycles after issue, then flush colliding with start.
        drive_cycle(1'b1, 1'b0, 64'd11, 64'd13, 5'd4);
        idle_cycle();
        drive_cycle(1'b0, 1'b1, rnd64(), rnd64(), 5'd0);
        repeat (6) idle_cycle();
        drive_cycle(1'b1, 1'b1, 64'd3, 64'd5, 5'd2);
        repeat (6) idle_cycle();

        // Random mix of starts and flushes.
        repeat (300)
            drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                        rnd64(), rnd64(), REG_W'($urandom));
        repeat (6) idle_cycle();

        // Asynchronous reset in the middle of BUSY with a nonzero accumulator.
        drive_cycle(1'b1, 1'b0, 64'h1234, 64'h5678, 5'd3);
        repeat (2) idle_cycle();
        do_reset_mid();
        repeat (3) idle_cycle();
        drive_cycle(1'b1, 1'b0, 64'd7, 64'd6, 5'd5);
        repeat (6) idle_cycle();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
